axi_mem_arb: RTL and testbench
==============================

AXI_MEM_ARB -- requirements
Module: axi_mem_arb

Interface
REQ-001 SHALL have parameter AW, default 8, meaning address width.
REQ-002 SHALL have parameter DW, default 32, meaning data width; wstrb width is DW/8.
REQ-003 SHALL use one clock, clk; reset, reset, is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 mN_req  input  1  request from requester N (N = 0, 1); held until mN_ack.
REQ-007 mN_we  input  1  1 = write, 0 = read.
REQ-008 mN_addr  input  AW  target address.
REQ-009 mN_wdata  input  DW  write data.
REQ-010 mN_ack  output  1  one-cycle pulse: request accepted.
REQ-011 mN_done  output  1  one-cycle pulse: transaction complete.
REQ-012 mN_rdata  output  DW  read data; valid while mN_done = 1.
REQ-013 mN_err  output  1  response was non-OKAY; valid while mN_done = 1.
REQ-014 awvalid/awready/awaddr  out/in/out  1/1/AW  AXI write address channel.
REQ-015 wvalid/wready/wdata/wstrb  out/in/out/out  1/1/DW/DW/8  AXI write data channel.
REQ-016 bvalid/bready/bresp  in/out/in  1/1/2  AXI write response channel.
REQ-017 arvalid/arready/araddr  out/in/out  1/1/AW  AXI read address channel.
REQ-018 rvalid/rready/rdata/rresp  in/out/in/in  1/1/DW/2  AXI read data channel.

Function
REQ-019 SHALL implement the states IDLE, WR, WR_RESP, RD_ADDR and RD_DATA, with at most one transaction outstanding.
REQ-020 In IDLE, when any mN_req = 1, SHALL grant one requester, latch its we/addr/wdata and owner, then move to WR (we = 1) or RD_ADDR (we = 0).
REQ-021 SHALL arbitrate round-robin: on contention, grant the requester not granted last; last_grant resets to 1, so m0 wins the first tie.
REQ-022 mN_ack SHALL be registered, high in the single cycle after the grant decision (the first cycle of WR/RD_ADDR); the requester drops req or presents a new request after ack.
REQ-023 WR: awvalid and wvalid SHALL assert together in the first WR cycle; each SHALL drop independently after its own valid&ready; the state SHALL advance to WR_RESP once both have completed, including when both complete in the same cycle.
REQ-024 wstrb SHALL be all ones; awaddr/wdata/araddr SHALL be stable while the corresponding valid is high.
REQ-025 WR_RESP: bready = 1; on bvalid, SHALL capture bresp != 0 into err and return to IDLE.
REQ-026 RD_ADDR: arvalid = 1 until arready; then RD_DATA: rready = 1 until rvalid, capture rdata and rresp != 0, then IDLE.
REQ-027 mN_done SHALL be registered, high for exactly one cycle, in the cycle after the final handshake, i.e. the first IDLE cycle, only for the owner; rdata/err SHALL hold until the next done.
REQ-028 Zero-wait slave latency: req at cycle T -> ack and awvalid/arvalid at T+1 -> bready/rready at T+2 -> done at T+3; arbitration of the next request SHALL occur at T+3.
REQ-029 bready/rready SHALL be 0 outside WR_RESP/RD_DATA; requests arriving while busy SHALL wait without loss.
REQ-030 mN_ack and mN_done SHALL never assert for both requesters in the same cycle.

Reset
REQ-031 While reset = 1, state = IDLE and all valid/ready/ack/done/err outputs SHALL be 0, mN_rdata = 0, last_grant = 1.
REQ-032 Reset mid-transaction SHALL abandon it with no done pulse; the valids SHALL be low in the cycle after reset is sampled.

Verification
REQ-033 m0 write addr 0x00 data 0xB4B4B4B4, zero-wait slave -> m0_ack at T+1, awaddr=0x00, wdata=0xB4B4B4B4, wstrb=0xF, m0_done at T+3, m0_err=0.
REQ-034 m1 read addr 0x04, slave returns 0xDEADBEEF after 3 wait cycles on rvalid -> m1_done once, m1_rdata=0xDEADBEEF, rready held throughout the wait.
REQ-035 m0 and m1 both request continuously for 4 transactions -> grant order m0, m1, m0, m1; no overlapping transactions.
REQ-036 Write with awready at T+1 and wready delayed 2 cycles -> awvalid low from T+2, wvalid held, WR_RESP entered only after the w handshake.
REQ-037 bresp=2'b10 -> owner err=1 with done; reset asserted during RD_DATA -> no done, all valids 0 on the next cycle, then the next request is served normally.

Source files
------------

// File: rtl/axi_mem_arb.sv
// ---------------------------------------------------------------------------
// axi_mem_arb
//
// Two-requester arbiter in front of a single AXI4-Lite-style memory port.
// One transaction is in flight at a time. Requesters are granted round-robin
// (m0 wins the first tie after reset), the winning request is latched and
// replayed on the AXI write (AW/W/B) or read (AR/R) channels, and completion
// is reported back to the owner with a one-cycle done pulse.
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   mN_req/we/addr/wdata  request from requester N (N = 0, 1), held until ack
//   mN_ack                one-cycle pulse: request accepted
//   mN_done               one-cycle pulse: transaction complete
//   mN_rdata, mN_err      read data / non-OKAY response, valid with mN_done
//   aw*, w*, b*           AXI write address, write data, write response
//   ar*, r*               AXI read address, read data
// ---------------------------------------------------------------------------
module axi_mem_arb #(
   parameter int AW = 8,
   parameter int DW = 32
) (
   input  logic            clk,
   input  logic            reset,
   // requester 0
   input  logic            m0_req,
   input  logic            m0_we,
   input  logic [AW-1:0]   m0_addr,
   input  logic [DW-1:0]   m0_wdata,
   output logic            m0_ack,
   output logic            m0_done,
   output logic [DW-1:0]   m0_rdata,
   output logic            m0_err,
   // requester 1
   input  logic            m1_req,
   input  logic            m1_we,
   input  logic [AW-1:0]   m1_addr,
   input  logic [DW-1:0]   m1_wdata,
   output logic            m1_ack,
   output logic            m1_done,
   output logic [DW-1:0]   m1_rdata,
   output logic            m1_err,
   // AXI write address channel
   output logic            awvalid,
   input  logic            awready,
   output logic [AW-1:0]   awaddr,
   // AXI write data channel
   output logic            wvalid,
   input  logic            wready,
   output logic [DW-1:0]   wdata,
   output logic [DW/8-1:0] wstrb,
   // AXI write response channel
   input  logic            bvalid,
   output logic            bready,
   input  logic [1:0]      bresp,
   // AXI read address channel
   output logic            arvalid,
   input  logic            arready,
   output logic [AW-1:0]   araddr,
   // AXI read data channel
   input  logic            rvalid,
   output logic            rready,
   input  logic [DW-1:0]   rdata,
   input  logic [1:0]      rresp
);

   typedef enum logic [2:0] {
      IDLE,
      WR,
      WR_RESP,
      RD_ADDR,
      RD_DATA
   } state_t;

   state_t          state_q;
   logic            owner_q;
   logic            last_grant_q;
   logic [AW-1:0]   addr_q;
   logic [DW-1:0]   wdata_q;
   logic            awvalid_q;
   logic            wvalid_q;
   logic            bready_q;
   logic            arvalid_q;
   logic            rready_q;
   logic [1:0]      ack_q;
   logic [1:0]      done_q;
   logic [1:0]      err_q;
   logic [DW-1:0]   rdata_q [2];

   // Grant decision and write-channel completion, evaluated every cycle.
   logic            req_any_d;
   logic            grant_d;
   logic            grant_we_d;
   logic [AW-1:0]   grant_addr_d;
   logic [DW-1:0]   grant_wdata_d;
   logic            aw_ok_d;
   logic            w_ok_d;

   always_comb begin
      // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
      req_any_d = m0_req | m1_req;
      // A lone requester wins outright; on a tie the one not granted last wins.
      grant_d   = m1_req;
      if (m0_req && m1_req) begin
         grant_d = ~last_grant_q;
      end
      grant_we_d    = grant_d ? m1_we    : m0_we;
      grant_addr_d  = grant_d ? m1_addr  : m0_addr;
      grant_wdata_d = grant_d ? m1_wdata : m0_wdata;
      // A write channel counts as finished once its valid has already dropped
      // or its handshake completes this cycle, so AW and W may finish in
      // either order or together.
      aw_ok_d = !awvalid_q || awready;
      w_ok_d  = !wvalid_q  || wready;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
         addr_q       <= '0;
         wdata_q      <= '0;
         awvalid_q    <= 1'b0;
         wvalid_q     <= 1'b0;
         bready_q     <= 1'b0;
         arvalid_q    <= 1'b0;
         rready_q     <= 1'b0;
         ack_q        <= '0;
         done_q       <= '0;
         err_q        <= '0;
         // NOTE: the read-data holding registers drive outputs directly, so they are reset like control state.
         for (int i = 0; i < 2; i++) begin
            rdata_q[i] <= '0;
         end
      end else begin
         // NOTE: sequential state uses <= so every register sees pre-edge values regardless of statement order.
         ack_q  <= '0;
         done_q <= '0;
         case (state_q)
            IDLE: begin
               if (req_any_d) begin
                  owner_q        <= grant_d;
                  last_grant_q   <= grant_d;
                  ack_q[grant_d] <= 1'b1;
                  addr_q         <= grant_addr_d;
                  wdata_q        <= grant_wdata_d;
                  if (grant_we_d) begin
                     state_q   <= WR;
                     awvalid_q <= 1'b1;
                     wvalid_q  <= 1'b1;
                  end else begin
                     state_q   <= RD_ADDR;
                     arvalid_q <= 1'b1;
                  end
               end
            end
            WR: begin
               if (awvalid_q && awready) begin
                  awvalid_q <= 1'b0;
               end
               if (wvalid_q && wready) begin
                  wvalid_q <= 1'b0;
               end
               if (aw_ok_d && w_ok_d) begin
                  state_q  <= WR_RESP;
                  bready_q <= 1'b1;
               end
            end
            WR_RESP: begin
               if (bvalid) begin
                  bready_q        <= 1'b0;
                  err_q[owner_q]  <= |bresp;
                  done_q[owner_q] <= 1'b1;
                  state_q         <= IDLE;
               end
            end
            RD_ADDR: begin
               if (arready) begin
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
                  state_q   <= RD_DATA;
               end
            end
            RD_DATA: begin
               if (rvalid) begin
                  rready_q         <= 1'b0;
                  rdata_q[owner_q] <= rdata;
                  err_q[owner_q]   <= |rresp;
                  done_q[owner_q]  <= 1'b1;
                  state_q          <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign m0_ack   = ack_q[0];
   assign m1_ack   = ack_q[1];
   assign m0_done  = done_q[0];
   assign m1_done  = done_q[1];
   assign m0_err   = err_q[0];
   assign m1_err   = err_q[1];
   assign m0_rdata = rdata_q[0];
   assign m1_rdata = rdata_q[1];

   assign awvalid  = awvalid_q;
   assign awaddr   = addr_q;
   assign wvalid   = wvalid_q;
   assign wdata    = wdata_q;
   assign wstrb    = {(DW/8){1'b1}};
   assign bready   = bready_q;
   assign arvalid  = arvalid_q;
   assign araddr   = addr_q;
   assign rready   = rready_q;

endmodule

// File: tb/tb_axi_mem_arb.sv
// ---------------------------------------------------------------------------
// tb_axi_mem_arb
//
// Directed scenarios followed by randomized two-requester traffic. A reactive
// AXI slave with per-channel wait counters lives in step(); a transaction-
// level model (round-robin rule, one-outstanding rule, flat memory array)
// predicts grants, completions and read data.
// ---------------------------------------------------------------------------
module tb_axi_mem_arb;

   localparam int AW = 8;
   localparam int DW = 32;

   logic            clk;
   logic            reset;
   logic            m0_req, m0_we, m0_ack, m0_done, m0_err;
   logic [AW-1:0]   m0_addr;
   logic [DW-1:0]   m0_wdata, m0_rdata;
   logic            m1_req, m1_we, m1_ack, m1_done, m1_err;
   logic [AW-1:0]   m1_addr;
   logic [DW-1:0]   m1_wdata, m1_rdata;
   logic            awvalid, awready, wvalid, wready, bvalid, bready;
   logic            arvalid, arready, rvalid, rready;
   logic [AW-1:0]   awaddr, araddr;
   logic [DW-1:0]   wdata, rdata;
   logic [DW/8-1:0] wstrb;
   logic [1:0]      bresp, rresp;

   axi_mem_arb #(.AW(AW), .DW(DW)) dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_ack(m0_ack), .m0_done(m0_done), .m0_rdata(m0_rdata), .m0_err(m0_err),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_ack(m1_ack), .m1_done(m1_done), .m1_rdata(m1_rdata), .m1_err(m1_err),
      .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
      .bvalid(bvalid), .bready(bready), .bresp(bresp),
      .arvalid(arvalid), .arready(arready), .araddr(araddr),
      .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------- reactive slave ----------------
   int            aw_wait, w_wait, b_wait, ar_wait, r_wait;
   int            aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
   bit            aw_got, w_got, rd_got, rand_waits, rand_resp;
   logic [AW-1:0] s_awaddr;
   logic [DW-1:0] s_wdata, cur_rdata;
   logic [1:0]    cur_bresp, cur_rresp, forced_bresp, forced_rresp;
   logic [DW-1:0] smem [64];

   function automatic int rnd_wait();
      if ($urandom_range(0, 1) == 0) return 0;
      return int'($urandom_range(1, 3));
   endfunction

   function automatic logic [1:0] rnd_resp(input logic [1:0] forced);
      if (!rand_resp) return forced;
      if ($urandom_range(0, 3) == 0) return 2'($urandom_range(2, 3));
      return 2'b00;
   endfunction

   // Advance one clock, then update the slave for the new cycle. Outputs
   // are examined by the caller 1 time unit after the rising edge.
   task automatic step();
      bit            aw_hs, w_hs, b_hs, ar_hs, r_hs;
      logic [AW-1:0] hs_awaddr, hs_araddr;
      logic [DW-1:0] hs_wdata;
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      b_hs  = bvalid && bready;
      ar_hs = arvalid && arready;
      r_hs  = rvalid && rready;
      hs_awaddr = awaddr;
      hs_wdata  = wdata;
      hs_araddr = araddr;
      @(posedge clk);
      #1;
      if (reset) begin
         aw_got = 0; w_got = 0; rd_got = 0;
         aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
      end else begin
         if (aw_hs) begin
            aw_got = 1; s_awaddr = hs_awaddr; aw_cnt = 0;
            if (rand_waits) aw_wait = rnd_wait();
         end
         if (w_hs) begin
            w_got = 1; s_wdata = hs_wdata; w_cnt = 0;
            if (rand_waits) w_wait = rnd_wait();
         end
         if ((aw_hs || w_hs) && aw_got && w_got) begin
            smem[s_awaddr[AW-1:2]] = s_wdata;
            cur_bresp = rnd_resp(forced_bresp);
            b_cnt = 0;
         end
         if (b_hs) begin
            aw_got = 0; w_got = 0;
            if (rand_waits) b_wait = rnd_wait();
         end
         if (ar_hs) begin
            rd_got = 1; ar_cnt = 0; r_cnt = 0;
            cur_rdata = smem[hs_araddr[AW-1:2]];
            cur_rresp = rnd_resp(forced_rresp);
            if (rand_waits) ar_wait = rnd_wait();
         end
         if (r_hs) begin
            rd_got = 0;
            if (rand_waits) r_wait = rnd_wait();
         end
      end
      awready = awvalid && (aw_cnt >= aw_wait);
      if (awvalid && !awready) aw_cnt++;
      wready = wvalid && (w_cnt >= w_wait);
      if (wvalid && !wready) w_cnt++;
      arready = arvalid && (ar_cnt >= ar_wait);
      if (arvalid && !arready) ar_cnt++;
      bvalid = aw_got && w_got && (b_cnt >= b_wait);
      if (aw_got && w_got && !bvalid) b_cnt++;
      bresp = bvalid ? cur_bresp : 2'b00;
      rvalid = rd_got && (r_cnt >= r_wait);
      if (rd_got && !rvalid) r_cnt++;
      rdata = rvalid ? cur_rdata : '0;
      rresp = rvalid ? cur_rresp : 2'b00;
   endtask

   // ---------------- transaction-level reference model ----------------
   bit            pend [2];
   bit            pwe [2];
   logic [AW-1:0] paddr [2];
   logic [DW-1:0] pwd [2];
   int            left [2];
   bit            infl, iwe;
   int            iown;
   logic [AW-1:0] iaddr;
   logic [DW-1:0] iwd;
   logic [DW-1:0] mmem [64];
   bit            idle_prev;
   bit            req_prev [2];
   int            mlast;
   int            busy_cyc;

   task automatic drive_reqs();
      m0_req = pend[0]; m0_we = pwe[0]; m0_addr = paddr[0]; m0_wdata = pwd[0];
      m1_req = pend[1]; m1_we = pwe[1]; m1_addr = paddr[1]; m1_wdata = pwd[1];
   endtask

   task automatic model_cycle();
      int n;
      bit exp_any;
      int exp_win;
      check("ack_onehot", m0_ack & m1_ack, 0);
      check("done_onehot", m0_done & m1_done, 0);
      if (m0_done || m1_done) begin
         n = m1_done ? 1 : 0;
         check("done_while_busy", infl, 1);
         check("done_owner", n, iown);
         check("done_err", n ? m1_err : m0_err, iwe ? (cur_bresp != 0) : (cur_rresp != 0));
         if (!iwe) check("done_rdata", n ? m1_rdata : m0_rdata, mmem[iaddr[AW-1:2]]);
         else mmem[iaddr[AW-1:2]] = iwd;
         infl = 0;
         busy_cyc = 0;
      end
      // A grant is due exactly when the arbiter was idle and someone asked.
      exp_any = idle_prev && (req_prev[0] || req_prev[1]);
      exp_win = (req_prev[0] && req_prev[1]) ? (1 - mlast) : (req_prev[1] ? 1 : 0);
      check("ack_timing", m0_ack | m1_ack, exp_any);
      if (m0_ack || m1_ack) begin
         n = m1_ack ? 1 : 0;
         if (exp_any) check("ack_winner", n, exp_win);
         infl = 1; iown = n; iwe = pwe[n]; iaddr = paddr[n]; iwd = pwd[n];
         pend[n] = 0; left[n]--; mlast = n;
      end
      check("wr_chan_scope", (awvalid | wvalid | bready) & !(infl & iwe), 0);
      check("rd_chan_scope", (arvalid | rready) & !(infl & !iwe), 0);
      if (awvalid) check("awaddr", awaddr, iaddr);
      if (wvalid) begin
         check("wdata", wdata, iwd);
         check("wstrb", wstrb, 4'hF);
      end
      if (arvalid) check("araddr", araddr, iaddr);
      if (infl) begin
         busy_cyc++;
         if (busy_cyc > 60) begin
            check("txn_timeout_cycles", busy_cyc, 60);
            infl = 0;
            busy_cyc = 0;
         end
      end
      for (int k = 0; k < 2; k++) begin
         if (!pend[k] && left[k] > 0 && $urandom_range(0, 3) != 0) begin
            pend[k]  = 1;
            pwe[k]   = 1'($urandom_range(0, 1));
            paddr[k] = AW'($urandom_range(0, 15) * 4);
            pwd[k]   = $urandom;
         end
      end
      drive_reqs();
      idle_prev   = !infl;
      req_prev[0] = pend[0];
      req_prev[1] = pend[1];
   endtask

   // ---------------- directed + random sequence ----------------
   int order [4];
   int acks, dones;
   bit busy;

   initial begin
      reset = 1'b1;
      m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
      m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
      awready = 0; wready = 0; bvalid = 0; bresp = '0;
      arready = 0; rvalid = 0; rdata = '0; rresp = '0;
      aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
      aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
      aw_got = 0; w_got = 0; rd_got = 0; rand_waits = 0; rand_resp = 0;
      forced_bresp = 2'b00; forced_rresp = 2'b00;
      cur_bresp = 2'b00; cur_rresp = 2'b00; cur_rdata = '0;
      s_awaddr = '0; s_wdata = '0;
      for (int i = 0; i < 64; i++) smem[i] = 32'hC0DE_0000 | DW'(i);
      for (int i = 0; i < 4; i++) order[i] = -1;

      // Reset: outputs quiet, and a request held during reset is not granted.
      step();
      m0_req = 1;
      step();
      check("rst_valids", {awvalid, wvalid, arvalid, bready, rready}, 0);
      check("rst_ack_done", {m0_ack, m1_ack, m0_done, m1_done}, 0);
      check("rst_err", {m0_err, m1_err}, 0);
      check("rst_m0_rdata", m0_rdata, 0);
      check("rst_m1_rdata", m1_rdata, 0);
      m0_req = 0;
      reset = 1'b0;
      step();

      // A: zero-wait write from m0.
      m0_we = 1; m0_addr = 8'h00; m0_wdata = 32'hB4B4_B4B4; m0_req = 1;
      step();
      check("A_ack", {m0_ack, m1_ack}, 2'b10);
      check("A_valids", {awvalid, wvalid}, 2'b11);
      check("A_awaddr", awaddr, 8'h00);
      check("A_wdata", wdata, 32'hB4B4_B4B4);
      check("A_wstrb", wstrb, 4'hF);
      m0_req = 0;
      step();
      check("A_bready", bready, 1);
      check("A_valids_low", {awvalid, wvalid}, 2'b00);
      check("A_no_early_done", m0_done, 0);
      step();
      check("A_done", m0_done, 1);
      check("A_err", m0_err, 0);
      check("A_bready_low", bready, 0);
      step();
      check("A_done_pulse", m0_done, 0);

      // B: m1 read with three wait cycles on rvalid.
      smem[1] = 32'hDEAD_BEEF;
      r_wait = 3;
      m1_we = 0; m1_addr = 8'h04; m1_req = 1;
      step();
      check("B_ack", {m0_ack, m1_ack}, 2'b01);
      check("B_arvalid", arvalid, 1);
      check("B_araddr", araddr, 8'h04);
      m1_req = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         check("B_rready_held", rready, 1);
         check("B_no_early_done", m1_done, 0);
      end
      step();
      check("B_done", m1_done, 1);
      check("B_rdata", m1_rdata, 32'hDEAD_BEEF);
      check("B_err", m1_err, 0);
      check("B_rready_low", rready, 0);
      step();
      check("B_done_pulse", m1_done, 0);
      r_wait = 0;

      // C: both requesters ask continuously for four transactions.
      m0_we = 0; m0_addr = 8'h08;
      m1_we = 1; m1_addr = 8'h0C; m1_wdata = 32'h1234_5678;
      m0_req = 1; m1_req = 1;
      acks = 0; dones = 0; busy = 0;
      for (int c = 0; c < 40 && dones < 4; c++) begin
         step();
         check("C_ack_onehot", m0_ack & m1_ack, 0);
         check("C_done_onehot", m0_done & m1_done, 0);
         if (m0_done || m1_done) begin
            busy = 0;
            dones++;
         end
         if (m0_ack || m1_ack) begin
            check("C_no_overlap", busy, 0);
            busy = 1;
            if (acks < 4) order[acks] = m1_ack ? 1 : 0;
            acks++;
            if (acks == 4) begin
               m0_req = 0;
               m1_req = 0;
            end
         end
      end
      check("C_ack_count", acks, 4);
      check("C_done_count", dones, 4);
      for (int i = 0; i < 4; i++) check("C_grant_order", order[i], i % 2);

      // D: awready at once, wready two cycles late.
      w_wait = 2;
      m0_we = 1; m0_addr = 8'h10; m0_wdata = 32'hA5A5_0F0F; m0_req = 1;
      step();
      check("D_ack", m0_ack, 1);
      check("D_valids", {awvalid, wvalid}, 2'b11);
      m0_req = 0;
      step();
      check("D_aw_dropped", {awvalid, wvalid}, 2'b01);
      check("D_wdata_stable", wdata, 32'hA5A5_0F0F);
      check("D_bready_wait1", bready, 0);
      step();
      check("D_wvalid_held", wvalid, 1);
      check("D_bready_wait2", bready, 0);
      step();
      check("D_wvalid_low", wvalid, 0);
      check("D_bready", bready, 1);
      step();
      check("D_done", m0_done, 1);
      w_wait = 0;

      // E1: error response on a write from m1.
      forced_bresp = 2'b10;
      m1_we = 1; m1_addr = 8'h14; m1_wdata = 32'h0BAD_F00D; m1_req = 1;
      step();
      check("E_ack", m1_ack, 1);
      m1_req = 0;
      step();
      step();
      check("E_done", m1_done, 1);
      check("E_err", m1_err, 1);
      forced_bresp = 2'b00;

      // E2: reset while waiting in the read-data phase.
      r_wait = 5;
      m0_we = 0; m0_addr = 8'h08; m0_req = 1;
      step();
      check("E_rd_ack", m0_ack, 1);
      m0_req = 0;
      step();
      check("E_in_rd_data", rready, 1);
      reset = 1'b1;
      step();
      check("E_rst_valids", {awvalid, wvalid, arvalid, bready, rready}, 0);
      check("E_rst_done", {m0_done, m1_done}, 0);
      check("E_rst_rdata", m0_rdata, 0);
      check("E_rst_err", {m0_err, m1_err}, 0);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         check("E_no_done_after_rst", {m0_done, m1_done}, 0);
         check("E_quiet_after_rst", {awvalid, wvalid, arvalid, bready, rready}, 0);
      end
      r_wait = 0;

      // E3: next request after reset is served normally.
      m1_we = 0; m1_addr = 8'h04; m1_req = 1;
      step();
      check("E_next_ack", m1_ack, 1);
      m1_req = 0;
      step();
      step();
      check("E_next_done", m1_done, 1);
      check("E_next_rdata", m1_rdata, 32'hDEAD_BEEF);
      check("E_next_err", m1_err, 0);

      // Randomized traffic against the reference model.
      for (int i = 0; i < 64; i++) mmem[i] = smem[i];
      rand_waits = 1; rand_resp = 1;
      for (int k = 0; k < 2; k++) begin
         pend[k] = 0; pwe[k] = 0; paddr[k] = '0; pwd[k] = '0; left[k] = 40;
         req_prev[k] = 0;
      end
      infl = 0; iwe = 0; iown = 0; iaddr = '0; iwd = '0;
      idle_prev = 1; mlast = 1; busy_cyc = 0;
      drive_reqs();
      for (int c = 0; c < 20000; c++) begin
         if (left[0] == 0 && left[1] == 0 && !pend[0] && !pend[1] && !infl) break;
         step();
         model_cycle();
      end
      check("rnd_all_complete", (left[0] + left[1] + int'(pend[0]) + int'(pend[1]) + int'(infl)) == 0, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
